// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception bit positions, trap cause codes,
// trap FSM state encoding and float field widths per result width.
package fpu_pkg;

  // Bit positions inside the 5-bit exception vector.
  localparam int EXC_OVF = 4;
  localparam int EXC_UNF = 3;
  localparam int EXC_DZ  = 2;
  localparam int EXC_INV = 1;
  localparam int EXC_NX  = 0;

  // Trap cause codes. The numeric order is also the priority order:
  // a lower nonzero code wins.
  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_INV  = 3'd1;
  localparam logic [2:0] CODE_DZ   = 3'd2;
  localparam logic [2:0] CODE_OVF  = 3'd3;
  localparam logic [2:0] CODE_UNF  = 3'd4;
  localparam logic [2:0] CODE_NX   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_COOL = 2'd2
  } exc_state_e;

  // IEEE binary32/64/128 exponent width. The exception stage uses this too.
  function automatic int exp_width(input int bw);
    case (bw)
      64:      return 11;
      128:     return 15;
      default: return 8;
    endcase
  endfunction

  function automatic int man_width(input int bw);
    return bw - 1 - exp_width(bw);
  endfunction

endpackage

// File: rtl/fpu_exc_prio_enc.sv
// Combinational 5-to-3 priority encoder for trap causes.
// Ports: i_cause - unmasked exception flags (fpu_pkg bit order)
//        o_code  - highest-priority cause code, CODE_NONE when no flag is set
module fpu_exc_prio_enc
  import fpu_pkg::*;
(
  input  logic [4:0] i_cause,
  output logic [2:0] o_code
);

  // Tests run from lowest to highest priority, so the last match wins.
  always_comb begin
    o_code = CODE_NONE;
    if (i_cause[EXC_NX])  o_code = CODE_NX;
    if (i_cause[EXC_UNF]) o_code = CODE_UNF;
    if (i_cause[EXC_OVF]) o_code = CODE_OVF;
    if (i_cause[EXC_DZ])  o_code = CODE_DZ;
    if (i_cause[EXC_INV]) o_code = CODE_INV;
  end

endmodule

// File: rtl/fpu_exc_status.sv
// FPU exception status and trap block. This block consumes result and
// exception vectors, accumulates sticky flags, and counts faulting results
// with a saturating counter. An unmasked exception raises a req/ack trap and
// stalls the input until the handshake ends and one cool-down cycle has passed.
// Ports: clk/rst (sync, active-high); i_valid/o_ready input handshake;
//        i_exception/i_result/i_tag input payload; i_mask_we/i_mask/o_mask trap mask;
//        i_clear clears sticky flags and the counter; o_sticky/o_exc_count status;
//        o_trap_req/i_trap_ack trap handshake; o_trap_cause/code/tag/result
//        captured trap details.
module fpu_exc_status
  import fpu_pkg::*;
#(
  parameter int         BIT_WIDTH = 32,
  parameter int         TAG_WIDTH = 6,
  parameter int         CNT_WIDTH = 16,
  parameter logic [4:0] MASK_RST  = 5'b11111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_exception,
  input  logic [BIT_WIDTH-1:0] i_result,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic                 i_mask_we,
  input  logic [4:0]           i_mask,
  input  logic                 i_clear,
  output logic [4:0]           o_mask,
  output logic [4:0]           o_sticky,
  output logic [CNT_WIDTH-1:0] o_exc_count,
  output logic                 o_trap_req,
  input  logic                 i_trap_ack,
  output logic [4:0]           o_trap_cause,
  output logic [2:0]           o_trap_code,
  output logic [TAG_WIDTH-1:0] o_trap_tag,
  output logic [BIT_WIDTH-1:0] o_trap_result
);

  exc_state_e           state_q, state_d;
  logic [4:0]           mask_q, mask_d;
  logic [4:0]           sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
  logic [4:0]           cause_q, cause_d;
  logic [2:0]           code_q, code_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [BIT_WIDTH-1:0] result_q, result_d;

  logic       accept, hit;
  logic [4:0] cause_in;
  logic [2:0] code_in;

  assign o_ready  = (state_q == ST_IDLE);
  assign accept   = i_valid & o_ready;
  // Use the mask before any write in this cycle.
  assign cause_in = i_exception & ~mask_q;
  assign hit      = accept & (|cause_in);

  fpu_exc_prio_enc u_prio (
    .i_cause (cause_in),
    .o_code  (code_in)
  );

  always_comb begin
    mask_d   = i_mask_we ? i_mask : mask_q;

    // Clear acts on the old state. The current accept still adds to the result.
    sticky_d = (i_clear ? 5'd0 : sticky_q) | (accept ? i_exception : 5'd0);
    cnt_base = i_clear ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && (|i_exception) && (cnt_base != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_base + CNT_WIDTH'(1);

    state_d  = state_q;
    cause_d  = cause_q;
    code_d   = code_q;
    tag_d    = tag_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: if (hit) begin
        state_d  = ST_TRAP;
        cause_d  = cause_in;
        code_d   = code_in;
        tag_d    = i_tag;
        result_d = i_result;
      end
      ST_TRAP: if (i_trap_ack) state_d = ST_COOL;
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= MASK_RST;
      sticky_q <= '0;
      cnt_q    <= '0;
      cause_q  <= '0;
      code_q   <= CODE_NONE;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      cause_q  <= cause_d;
      code_q   <= code_d;
      tag_q    <= tag_d;
      result_q <= result_d;
    end
  end

  assign o_mask        = mask_q;
  assign o_sticky      = sticky_q;
  assign o_exc_count   = cnt_q;
  assign o_trap_req    = (state_q == ST_TRAP);
  assign o_trap_cause  = cause_q;
  assign o_trap_code   = code_q;
  assign o_trap_tag    = tag_q;
  assign o_trap_result = result_q;

endmodule

// File: tb/tb_fpu_exc_status.sv
module tb_fpu_exc_status;
  localparam int BW  = 32;
  localparam int TW  = 6;
  localparam int CW  = 4;   // small counter so saturation is reachable
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst, i_valid, o_ready, i_mask_we, i_clear, o_trap_req, i_trap_ack;
  logic [4:0]    i_exception, i_mask, o_mask, o_sticky, o_trap_cause;
  logic [BW-1:0] i_result, o_trap_result;
  logic [TW-1:0] i_tag, o_trap_tag;
  logic [CW-1:0] o_exc_count;
  logic [2:0]    o_trap_code;

  fpu_exc_status #(.BIT_WIDTH(BW), .TAG_WIDTH(TW), .CNT_WIDTH(CW), .MASK_RST(5'b11111)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_exception(i_exception), .i_result(i_result), .i_tag(i_tag),
    .i_mask_we(i_mask_we), .i_mask(i_mask), .i_clear(i_clear),
    .o_mask(o_mask), .o_sticky(o_sticky), .o_exc_count(o_exc_count),
    .o_trap_req(o_trap_req), .i_trap_ack(i_trap_ack),
    .o_trap_cause(o_trap_cause), .o_trap_code(o_trap_code),
    .o_trap_tag(o_trap_tag), .o_trap_result(o_trap_result));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Behavioural model: a pending trap, a cool-down flag, and the plain values.
  bit      m_pending, m_cool;
  int      m_mask, m_sticky, m_count, m_cause, m_code, m_tag;
  longint  m_result;

  function automatic int prio_code(input int cause);
    int order[5] = '{1, 2, 4, 3, 0};  // invalid, dz, ovf, unf, inexact
    for (int k = 0; k < 5; k++)
      if (cause[order[k]]) return k + 1;
    return 0;
  endfunction

  task automatic model_edge();
    bit acc;
    int old_mask;
    if (rst) begin
      m_pending = 0; m_cool = 0; m_mask = 31; m_sticky = 0; m_count = 0;
      m_cause = 0; m_code = 0; m_tag = 0; m_result = 0;
      return;
    end
    acc = i_valid && !m_pending && !m_cool;
    old_mask = m_mask;
    if (i_clear) begin m_sticky = 0; m_count = 0; end
    if (acc) begin
      m_sticky = m_sticky | int'(i_exception);
      if (i_exception != 0 && m_count < MAX) m_count = m_count + 1;
    end
    if (i_mask_we) m_mask = int'(i_mask);
    if (m_cool) m_cool = 0;
    else if (m_pending) begin
      if (i_trap_ack) begin m_pending = 0; m_cool = 1; end
    end else if (acc && ((int'(i_exception) & ~old_mask & 31) != 0)) begin
      m_pending = 1;
      m_cause   = int'(i_exception) & ~old_mask & 31;
      m_code    = prio_code(m_cause);
      m_tag     = int'(i_tag);
      m_result  = longint'(i_result);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("ready",  64'(o_ready),       64'(!m_pending && !m_cool));
    chk("req",    64'(o_trap_req),    64'(m_pending));
    chk("mask",   64'(o_mask),        64'(m_mask));
    chk("sticky", 64'(o_sticky),      64'(m_sticky));
    chk("count",  64'(o_exc_count),   64'(m_count));
    chk("cause",  64'(o_trap_cause),  64'(m_cause));
    chk("code",   64'(o_trap_code),   64'(m_code));
    chk("tag",    64'(o_trap_tag),    64'(m_tag));
    chk("result", 64'(o_trap_result), 64'(m_result));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
  endtask

  task automatic quiet();
    rst = 0; i_valid = 0; i_exception = 0; i_result = 0; i_tag = 0;
    i_mask_we = 0; i_mask = 0; i_clear = 0; i_trap_ack = 0;
  endtask

  task automatic set_mask(input logic [4:0] m);
    quiet(); i_mask_we = 1; i_mask = m; tick(); quiet();
  endtask

  task automatic send(input logic [4:0] e, input logic [TW-1:0] t, input logic [BW-1:0] r);
    quiet(); i_valid = 1; i_exception = e; i_tag = t; i_result = r; tick(); quiet();
  endtask

  task automatic ack_trap();
    quiet(); i_trap_ack = 1; tick(); quiet(); tick();
  endtask

  initial begin
    quiet();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_mask", 64'(o_mask), 64'h1f);
    chk("rst_ready", 64'(o_ready), 64'h1);
    chk("rst_req", 64'(o_trap_req), 64'h0);

    // Masked accumulation.
    send(5'b00001, 6'h01, 32'h1);
    send(5'b10000, 6'h02, 32'h2);
    send(5'b00000, 6'h03, 32'h3);
    chk("acc_sticky", 64'(o_sticky), 64'h11);
    chk("acc_count", 64'(o_exc_count), 64'h2);
    chk("acc_noreq", 64'(o_trap_req), 64'h0);

    // Trap handshake.
    set_mask(5'b11101);
    send(5'b00011, 6'h2A, 32'h7FC00000);
    chk("trap_req", 64'(o_trap_req), 64'h1);
    chk("trap_cause", 64'(o_trap_cause), 64'h02);
    chk("trap_code", 64'(o_trap_code), 64'h1);
    chk("trap_tag", 64'(o_trap_tag), 64'h2A);
    chk("trap_res", 64'(o_trap_result), 64'h7FC00000);
    chk("trap_ready", 64'(o_ready), 64'h0);
    i_valid = 1; i_exception = 5'b11111; i_tag = 6'h3F; i_result = 32'hDEAD;
    tick(); tick(); tick();
    chk("stall_sticky", 64'(o_sticky), 64'h13);
    quiet(); i_trap_ack = 1; tick(); quiet();
    chk("ack_req", 64'(o_trap_req), 64'h0);
    chk("cool_ready", 64'(o_ready), 64'h0);
    tick();
    chk("post_ready", 64'(o_ready), 64'h1);

    // Priority.
    set_mask(5'b00000);
    send(5'b11100, 6'h05, 32'h55);
    chk("prio_cause", 64'(o_trap_cause), 64'h1C);
    chk("prio_code", 64'(o_trap_code), 64'h2);
    ack_trap();

    // Clear and accept in the same cycle, then saturation.
    set_mask(5'b11111);
    quiet(); i_clear = 1; tick(); quiet();
    send(5'b00100, 6'h0, 32'h0);
    for (int k = 0; k < 6; k++) send(5'b00001, 6'h0, 32'h0);
    chk("pre_sticky", 64'(o_sticky), 64'h05);
    chk("pre_count", 64'(o_exc_count), 64'h7);
    quiet(); i_clear = 1; i_valid = 1; i_exception = 5'b01000; tick(); quiet();
    chk("clr_sticky", 64'(o_sticky), 64'h08);
    chk("clr_count", 64'(o_exc_count), 64'h1);
    for (int k = 0; k < 20; k++) send(5'b00010, 6'h0, 32'h0);
    chk("sat_count", 64'(o_exc_count), 64'(MAX));

    // Mask race, then reset mid-trap.
    set_mask(5'b00000);
    quiet(); i_mask_we = 1; i_mask = 5'b11111; i_valid = 1; i_exception = 5'b00100;
    i_tag = 6'h11; i_result = 32'hABCD; tick(); quiet();
    chk("race_req", 64'(o_trap_req), 64'h1);
    chk("race_mask", 64'(o_mask), 64'h1f);
    rst = 1; i_trap_ack = 1; tick(); quiet();
    chk("rst_trap_req", 64'(o_trap_req), 64'h0);
    chk("rst_trap_ready", 64'(o_ready), 64'h1);
    chk("rst_trap_mask", 64'(o_mask), 64'h1f);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      i_valid     = $urandom_range(0, 1);
      i_exception = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      i_result    = $urandom;
      i_tag       = 6'($urandom);
      i_mask_we   = ($urandom_range(0, 7) == 0);
      i_mask      = 5'($urandom);
      i_clear     = ($urandom_range(0, 15) == 0);
      i_trap_ack  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
